// File: rtl/axis_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axis_arb_pkg
//  Description : Shared types and constants for the two-source C2H arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package axis_arb_pkg;

    localparam int NUM_SOURCES         = 2;
    localparam int DEFAULT_DATA_WIDTH  = 64;
    localparam int DEFAULT_COUNT_WIDTH = 32;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/axis_c2h_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : axis_c2h_arbiter_if
//  Description : AXI-Stream bundle (tdata/tkeep/tlast/tvalid/tready).
//  Revision    : 1.0 - initial release
// ============================================================================
interface axis_c2h_arbiter_if
    import axis_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();

    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tlast;
    logic                    tvalid;
    logic                    tready;

    modport master (output tdata, output tkeep, output tlast, output tvalid, input  tready);
    modport slave  (input  tdata, input  tkeep, input  tlast, input  tvalid, output tready);

endinterface
`default_nettype wire

// File: rtl/axis_reg_stage.sv
`default_nettype none
// ============================================================================
//  Module      : axis_reg_stage
//  Description : Single-entry AXI-Stream register slice, ready = ~valid | m_tready.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_reg_stage
    import axis_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    input  wire logic [DATA_WIDTH-1:0]   s_tdata_i,
    input  wire logic [DATA_WIDTH/8-1:0] s_tkeep_i,
    input  wire logic                    s_tlast_i,
    input  wire logic                    s_tvalid_i,
    output logic                         s_tready_o,
    output logic [DATA_WIDTH-1:0]        m_tdata_o,
    output logic [DATA_WIDTH/8-1:0]      m_tkeep_o,
    output logic                         m_tlast_o,
    output logic                         m_tvalid_o,
    input  wire logic                    m_tready_i
);

    logic [DATA_WIDTH-1:0]   tdata_q;
    logic [DATA_WIDTH/8-1:0] tkeep_q;
    logic                    tlast_q;
    logic                    tvalid_q;

    assign s_tready_o = ~tvalid_q | m_tready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tlast_q  <= 1'b0;
            tvalid_q <= 1'b0;
        end else if (s_tvalid_i && s_tready_o) begin
            tdata_q  <= s_tdata_i;
            tkeep_q  <= s_tkeep_i;
            tlast_q  <= s_tlast_i;
            tvalid_q <= 1'b1;
        end else if (m_tready_i) begin
            tvalid_q <= 1'b0;
        end
    end

    assign m_tdata_o  = tdata_q;
    assign m_tkeep_o  = tkeep_q;
    assign m_tlast_o  = tlast_q;
    assign m_tvalid_o = tvalid_q;

endmodule
`default_nettype wire

// File: rtl/axis_c2h_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : axis_c2h_arbiter
//  Description : Packet-locked round-robin merge of two AXI-Stream sources.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_c2h_arbiter
    import axis_arb_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
    input  wire logic                   AXI_clock,
    input  wire logic                   AXI_reset,
    axis_c2h_arbiter_if.slave           S0,
    axis_c2h_arbiter_if.slave           S1,
    axis_c2h_arbiter_if.master          M,
    input  wire logic [NUM_SOURCES-1:0] ARB_enable,
    input  wire logic                   ARB_count_clear,
    output logic [COUNT_WIDTH-1:0]      ARB_pkt_count0,
    output logic [COUNT_WIDTH-1:0]      ARB_pkt_count1,
    output logic                        ARB_busy
);

    localparam int KEEP_WIDTH = DATA_WIDTH / 8;

    arb_state_e state_q, state_d;
    logic       grant_q, grant_d;
    logic       last_grant_q, last_grant_d;

    logic [NUM_SOURCES-1:0] w_req;
    logic                   w_pick;
    logic [DATA_WIDTH-1:0]  w_sel_tdata;
    logic [KEEP_WIDTH-1:0]  w_sel_tkeep;
    logic                   w_sel_tlast;
    logic                   w_sel_tvalid;
    logic                   w_sel_tready;
    logic                   w_up_ready;
    logic                   w_accept;

    logic [COUNT_WIDTH-1:0] cnt_q [NUM_SOURCES];
    logic [COUNT_WIDTH-1:0] cnt_d [NUM_SOURCES];

    // On a tie the source that did not win last time gets the grant.
    always_comb begin
        w_req = {S1.tvalid & ARB_enable[1], S0.tvalid & ARB_enable[0]};
        if (&w_req) begin
            w_pick = ~last_grant_q;
        end else begin
            w_pick = ~w_req[0];
        end
    end

    always_comb begin
        w_sel_tdata  = grant_q ? S1.tdata  : S0.tdata;
        w_sel_tkeep  = grant_q ? S1.tkeep  : S0.tkeep;
        w_sel_tlast  = grant_q ? S1.tlast  : S0.tlast;
        w_sel_tvalid = grant_q ? S1.tvalid : S0.tvalid;
        // Reset gating keeps the source from seeing a handshake that is about to be discarded.
        w_sel_tready = (state_q == ST_LOCKED) & w_up_ready & ~AXI_reset;
        w_accept     = w_sel_tvalid & w_sel_tready;
    end

    assign S0.tready = w_sel_tready & ~grant_q;
    assign S1.tready = w_sel_tready &  grant_q;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                if (|w_req) begin
                    state_d      = ST_LOCKED;
                    grant_d      = w_pick;
                    last_grant_d = w_pick;
                end
            end
            ST_LOCKED: begin
                if (w_accept && w_sel_tlast) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge AXI_clock) begin
        if (AXI_reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    generate
        for (genvar i = 0; i < NUM_SOURCES; i++) begin : g_cnt
            always_comb begin
                cnt_d[i] = cnt_q[i];
                if (ARB_count_clear) begin
                    cnt_d[i] = '0;
                end else if (w_accept && w_sel_tlast && (grant_q == 1'(i))) begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end

            always_ff @(posedge AXI_clock) begin
                if (AXI_reset) begin
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_d[i];
                end
            end
        end
    endgenerate

    assign ARB_pkt_count0 = cnt_q[0];
    assign ARB_pkt_count1 = cnt_q[1];

    axis_reg_stage #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_reg (
        .clk        (AXI_clock),
        .rst        (AXI_reset),
        .s_tdata_i  (w_sel_tdata),
        .s_tkeep_i  (w_sel_tkeep),
        .s_tlast_i  (w_sel_tlast),
        .s_tvalid_i (w_accept),
        .s_tready_o (w_up_ready),
        .m_tdata_o  (M.tdata),
        .m_tkeep_o  (M.tkeep),
        .m_tlast_o  (M.tlast),
        .m_tvalid_o (M.tvalid),
        .m_tready_i (M.tready)
    );

    assign ARB_busy = (state_q == ST_LOCKED) | M.tvalid;

endmodule
`default_nettype wire

// File: tb/tb_axis_c2h_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axis_c2h_arbiter
//  Description : Scoreboard bench for axis_c2h_arbiter with a packet-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_c2h_arbiter;

    localparam int DW       = 64;
    localparam int KW       = DW / 8;
    localparam int CW       = 8;
    localparam int WAIT_MAX = 3000;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] s_tdata  [2];
    logic [KW-1:0] s_tkeep  [2];
    logic          s_tlast  [2];
    logic          s_tvalid [2];
    logic          s_tready [2];
    logic          m_ready;
    logic [1:0]    arb_en;
    logic          arb_clr;
    logic [CW-1:0] cnt0, cnt1;
    logic          busy;

    int            n_cmp = 0;
    int            n_err = 0;
    beat_t         exp_q [2][$];
    int            exp_order [$];
    logic [CW-1:0] mdl_cnt [2];
    bit            rand_ready = 1'b0;

    // monitor state
    bit            in_pkt  = 1'b0;
    int            cur_src = 0;
    int            cyc     = 0;
    int            pkt_start = 0;
    int            last_span = -1;
    bit            stall_q = 1'b0;
    logic [DW+KW:0] held;

    axis_c2h_arbiter_if #(.DATA_WIDTH(DW)) s0_if ();
    axis_c2h_arbiter_if #(.DATA_WIDTH(DW)) s1_if ();
    axis_c2h_arbiter_if #(.DATA_WIDTH(DW)) m_if ();

    assign s0_if.tdata  = s_tdata[0];
    assign s0_if.tkeep  = s_tkeep[0];
    assign s0_if.tlast  = s_tlast[0];
    assign s0_if.tvalid = s_tvalid[0];
    assign s_tready[0]  = s0_if.tready;
    assign s1_if.tdata  = s_tdata[1];
    assign s1_if.tkeep  = s_tkeep[1];
    assign s1_if.tlast  = s_tlast[1];
    assign s1_if.tvalid = s_tvalid[1];
    assign s_tready[1]  = s1_if.tready;
    assign m_if.tready  = m_ready;

    axis_c2h_arbiter #(
        .DATA_WIDTH  (DW),
        .COUNT_WIDTH (CW)
    ) dut (
        .AXI_clock       (clk),
        .AXI_reset       (rst),
        .S0              (s0_if),
        .S1              (s1_if),
        .M               (m_if),
        .ARB_enable      (arb_en),
        .ARB_count_clear (arb_clr),
        .ARB_pkt_count0  (cnt0),
        .ARB_pkt_count1  (cnt1),
        .ARB_busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Presents one packet on source src; the model counters follow the handshake.
    task automatic send_pkt(input int src, input int len, input int gap_pct, input bit pat, input bit clr_last);
        beat_t b;
        int    w;
        for (int k = 0; k < len; k++) begin
            while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                s_tvalid[src] = 1'b0;
                @(posedge clk); #1;
            end
            b.data = pat ? DW'(k + 1) * DW'('h11) : {src[0], $urandom(), 31'($urandom())};
            b.keep = pat ? {KW{1'b1}} : KW'($urandom_range(1, 255));
            b.last = (k == len - 1);
            s_tdata[src]  = b.data;
            s_tkeep[src]  = b.keep;
            s_tlast[src]  = b.last;
            s_tvalid[src] = 1'b1;
            exp_q[src].push_back(b);
            w = 0;
            @(negedge clk);
            while (!s_tready[src] && w < WAIT_MAX) begin
                w++;
                @(negedge clk);
            end
            if (!s_tready[src]) begin
                n_cmp++;
                n_err++;
                $display("FAIL handshake_timeout src=%0d: got no tready, required tready within %0d cycles", src, WAIT_MAX);
                s_tvalid[src] = 1'b0;
                return;
            end
            if (b.last) begin
                if (clr_last) begin
                    arb_clr    = 1'b1;
                    mdl_cnt[0] = '0;
                    mdl_cnt[1] = '0;
                end else begin
                    mdl_cnt[src] = mdl_cnt[src] + 1'b1;
                end
            end
            @(posedge clk); #1;
            if (clr_last) arb_clr = 1'b0;
            s_tvalid[src] = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_counts(input string nm);
        @(negedge clk);
        chk({nm, "_cnt0"}, cnt0, mdl_cnt[0]);
        chk({nm, "_cnt1"}, cnt1, mdl_cnt[1]);
        chk({nm, "_busy"}, busy, 1'b0);
        chk({nm, "_drained"}, exp_q[0].size() + exp_q[1].size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_ready) m_ready = ($urandom_range(0, 3) != 0);
        end
    end

    always @(negedge clk) begin
        int src;
        cyc++;
        if (rst) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) chk("hold_stable", {m_if.tdata, m_if.tkeep, m_if.tlast}, held);
            if (m_if.tvalid && !m_if.tready) begin
                chk("src_ready_during_stall", {s_tready[1], s_tready[0]}, 2'b00);
                held    = {m_if.tdata, m_if.tkeep, m_if.tlast};
                stall_q = 1'b1;
            end else begin
                stall_q = 1'b0;
            end
            if (m_if.tvalid && m_if.tready) begin
                src = int'(m_if.tdata[DW-1]);
                if (!in_pkt) begin
                    pkt_start = cyc;
                    if (exp_order.size() > 0) chk("grant_order", src, exp_order.pop_front());
                end else begin
                    chk("no_interleave", src, cur_src);
                end
                if (exp_q[src].size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_beat: got %0h from src %0d, required nothing", m_if.tdata, src);
                end else begin
                    chk("beat", {m_if.tdata, m_if.tkeep, m_if.tlast}, exp_q[src].pop_front());
                end
                in_pkt  = !m_if.tlast;
                cur_src = src;
                if (m_if.tlast) last_span = cyc - pkt_start;
            end
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: got no completion, required finish within 60000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        beat_t b;
        int    w;
        for (int i = 0; i < 2; i++) begin
            s_tdata[i] = '0; s_tkeep[i] = '0; s_tlast[i] = 1'b0; s_tvalid[i] = 1'b0;
            mdl_cnt[i] = '0;
        end
        m_ready = 1'b1;
        arb_en  = 2'b11;
        arb_clr = 1'b0;

        // reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_m_tvalid", m_if.tvalid, 1'b0);
        chk("rst_m_bus", {m_if.tdata, m_if.tkeep, m_if.tlast}, '0);
        chk("rst_s_tready", {s_tready[1], s_tready[0]}, 2'b00);
        chk("rst_counts", {cnt1, cnt0}, '0);
        chk("rst_busy", busy, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        // continuous 2-beat offers from both: strict alternation from S0
        exp_order = '{0, 1, 0, 1};
        fork
            begin send_pkt(0, 2, 0, 0, 0); send_pkt(0, 2, 0, 0, 0); end
            begin send_pkt(1, 2, 0, 0, 0); send_pkt(1, 2, 0, 0, 0); end
        join
        idle(3);
        chk("rr_order_consumed", exp_order.size(), 0);
        chk("rr_count0", cnt0, 2);
        chk("rr_count1", cnt1, 2);
        check_counts("rr");

        // fixed 3-beat packet streams on consecutive cycles
        send_pkt(0, 3, 0, 1, 0);
        idle(3);
        chk("pkt3_span", last_span, 2);
        check_counts("pkt3");

        // 5-cycle downstream stall mid-packet
        fork
            send_pkt(0, 6, 0, 0, 0);
            begin idle(3); m_ready = 1'b0; idle(5); m_ready = 1'b1; end
        join
        idle(3);
        check_counts("stall");

        // source 0 disabled: only S1 wins until bit 0 returns
        arb_en    = 2'b10;
        exp_order = '{1, 1, 0};
        fork
            send_pkt(0, 1, 0, 0, 0);
            begin
                send_pkt(1, 2, 20, 0, 0);
                send_pkt(1, 3, 20, 0, 0);
                idle(3);
                arb_en = 2'b11;
            end
        join
        idle(3);
        chk("enable_order_consumed", exp_order.size(), 0);
        check_counts("enable");

        // enable dropped mid-packet does not truncate
        exp_order = '{0};
        fork
            send_pkt(0, 5, 0, 0, 0);
            begin idle(2); arb_en = 2'b10; end
        join
        arb_en = 2'b11;
        idle(3);
        check_counts("enable_drop");

        // clear coincident with tlast acceptance wins
        send_pkt(0, 2, 0, 0, 1);
        idle(3);
        chk("clear_priority", cnt0, 0);
        check_counts("clear");

        // counter wrap
        for (int i = 0; i < (1 << CW) - 1; i++) send_pkt(0, 1, 0, 0, 0);
        idle(3);
        chk("count_at_max", cnt0, {CW{1'b1}});
        send_pkt(0, 1, 0, 0, 0);
        idle(3);
        chk("count_wrapped", cnt0, 0);
        check_counts("wrap");

        // randomized traffic with random backpressure
        rand_ready = 1'b1;
        fork
            for (int i = 0; i < 25; i++) send_pkt(0, $urandom_range(1, 5), 25, 0, 0);
            for (int j = 0; j < 25; j++) send_pkt(1, $urandom_range(1, 5), 25, 0, 0);
        join
        rand_ready = 1'b0;
        m_ready    = 1'b1;
        idle(4);
        check_counts("random");

        // reset on beat 2 of a 4-beat packet
        b.data = {1'b0, 63'($urandom())};
        b.keep = {KW{1'b1}};
        b.last = 1'b0;
        s_tdata[0] = b.data; s_tkeep[0] = b.keep; s_tlast[0] = 1'b0; s_tvalid[0] = 1'b1;
        exp_q[0].push_back(b);
        w = 0;
        @(negedge clk);
        while (!s_tready[0] && w < WAIT_MAX) begin w++; @(negedge clk); end
        chk("rst_test_beat1_ready", s_tready[0], 1'b1);
        @(posedge clk); #1;
        s_tdata[0] = {1'b0, 63'($urandom())};
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        s_tvalid[0] = 1'b0;
        exp_q[0].delete();
        exp_q[1].delete();
        in_pkt = 1'b0;
        mdl_cnt[0] = '0;
        mdl_cnt[1] = '0;
        @(negedge clk);
        chk("midrst_m_tvalid", m_if.tvalid, 1'b0);
        chk("midrst_counts", {cnt1, cnt0}, '0);
        @(posedge clk); #1;
        send_pkt(1, 3, 0, 0, 0);
        idle(3);
        check_counts("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axis_c2h_arbiter.md
AXIS_C2H_ARBITER -- requirements
Module: axis_c2h_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 64: width of every tdata bus; tkeep width is DATA_WIDTH/8.
REQ-002 Parameter COUNT_WIDTH, default 32: width of each per-source packet counter.
REQ-003 AXI_clock  input  1  sole clock; all logic is on its rising edge.
REQ-004 AXI_reset  input  1  synchronous, active-high reset.
REQ-005 S0_tdata/S0_tkeep/S0_tlast/S0_tvalid  input  DATA_WIDTH/DATA_WIDTH/8/1/1  source 0 AXI-Stream; S0_tready output 1.
REQ-006 S1_tdata/S1_tkeep/S1_tlast/S1_tvalid  input  same widths  source 1 AXI-Stream; S1_tready output 1.
REQ-007 M_tdata/M_tkeep/M_tlast/M_tvalid  output  DATA_WIDTH/DATA_WIDTH/8/1/1  merged C2H stream; M_tready input 1.
REQ-008 ARB_enable  input  2  per-source grant enable, bit i for source i.
REQ-009 ARB_count_clear  input  1  single-cycle pulse that zeroes both packet counters.
REQ-010 ARB_pkt_count0/ARB_pkt_count1  output  COUNT_WIDTH  packets completed per source.
REQ-011 ARB_busy  output  1  high when the FSM is in LOCKED or M_tvalid is high.

Function
REQ-012 FSM states: IDLE and LOCKED.
REQ-013 In IDLE, a request is Si_tvalid & ARB_enable[i]; with no request, the FSM stays in IDLE.
REQ-014 With one request, IDLE grants that source; with two, it grants the source other than last_grant (round-robin); last_grant resets to 1, so source 0 wins the first tie.
REQ-015 A grant registers the grant index and sets last_grant to it at the same edge; the FSM moves to LOCKED; all Si_tready are 0 in IDLE.
REQ-016 In LOCKED, Sg_tready = ~M_tvalid | M_tready for the granted source g; the non-granted S_tready is 0.
REQ-017 A beat is accepted when Sg_tvalid & Sg_tready; it loads the output register, giving M_tvalid one cycle after acceptance.
REQ-018 On acceptance of a beat with Sg_tlast=1, the FSM returns to IDLE at that edge: one arbitration bubble cycle per packet.
REQ-019 The output register holds tdata/tkeep/tlast stable while M_tvalid & ~M_tready, and it clears M_tvalid when M_tready is high with no new beat.
REQ-020 Sustained throughput within a packet is one beat per cycle while M_tready stays high.
REQ-021 Deasserting ARB_enable[i] mid-packet does not truncate the packet; it only blocks future grants.
REQ-022 Source tvalid dropping mid-packet stalls the block in LOCKED; no timeout exists.
REQ-023 ARB_pkt_counti increments by 1 on each accepted tlast beat from source i and wraps modulo 2^COUNT_WIDTH.
REQ-024 ARB_count_clear has priority over a same-cycle increment; the counter becomes 0.
REQ-025 tkeep passes unmodified; no packet is reordered, interleaved, or dropped.

Reset
REQ-026 While AXI_reset is high: FSM=IDLE, last_grant=1, M_tvalid=0, M_tdata=0, M_tkeep=0, M_tlast=0, S0_tready=S1_tready=0, counters=0, ARB_busy=0.
REQ-027 Reset asserted mid-packet discards the in-flight beat and the rest of the packet; after reset, arbitration restarts from IDLE.

Structure
REQ-028 Package axis_arb_pkg holds the FSM state enum (IDLE, LOCKED), NUM_SOURCES=2, and default DATA_WIDTH/COUNT_WIDTH constants.
REQ-029 The output register is the sub-module axis_reg_stage: a single-entry register, ready = ~valid | downstream ready.
REQ-030 Arbitration FSM, grant mux and counters reside in axis_c2h_arbiter.

Verification
REQ-031 Reset, then a 3-beat S0 packet (tdata 0x11,0x22,0x33, tlast on beat 3), M_tready=1 -> M emits 0x11,0x22,0x33 on consecutive cycles, tlast on 0x33; ARB_pkt_count0=1.
REQ-032 Both sources continuously offer 2-beat packets, ARB_enable=2'b11 -> grants alternate S0,S1,S0,S1 starting with S0; after 4 packets each counter equals 2.
REQ-033 During an S0 packet, M_tready=0 for 5 cycles -> M_tdata/M_tkeep/M_tlast stay stable, S0_tready=0, and no beat is lost or duplicated.
REQ-034 ARB_enable=2'b10 with both sources valid -> only S1 is granted; clearing bit 0 during an S0 packet lets that packet complete intact.
REQ-035 AXI_reset pulsed on beat 2 of a 4-beat packet -> next cycle M_tvalid=0 and counters=0; a fresh S1 packet then passes correctly.
REQ-036 ARB_count_clear asserted in the same cycle as an S0 tlast acceptance -> ARB_pkt_count0=0; a counter preset near 0xFFFFFFFF wraps to 0 after the next packet.
